// File: rtl/tri_line_pkg.sv
// Shared types and defaults for the single-wire tri-state line.
// Used by the receiver here and by the matching transmitter.
package tri_line_pkg;

    localparam int DATA_W_DEF       = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/line_sync.sv
// Two-flop synchronizer for the shared line, idle-high reset.
// Outputs the synced level and a one-cycle falling-edge pulse.
module line_sync (
    input  logic clk,
    input  logic resetN,
    input  wire  line_inN,
    output logic level,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // Only a solid 0 counts as low; Z/X fall into the else branch.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync2_d <= 1'b1;
        end else begin
            if (line_inN == 1'b0)
                sync1 <= 1'b0;
            else
                sync1 <= 1'b1;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign level = sync2;
    assign fall  = sync2_d & ~sync2;

endmodule

// File: rtl/tri_line_rx.sv
// Receiver for the inverting single-wire line: mid-bit sampling,
// LSB-first deserialization, stop-bit check, one word per frame.
module tri_line_rx
    import tri_line_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              resetN,
    input  wire               line_inN,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    logic level;
    logic fall;

    rx_state_t         state,   state_n;
    logic [CNT_W-1:0]  clk_cnt, clk_cnt_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [DATA_W-1:0] dout_n;
    logic              valid_n;
    logic              err_n;

    line_sync u_sync (
        .clk      (clk),
        .resetN   (resetN),
        .line_inN (line_inN),
        .level    (level),
        .fall     (fall)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            clk_cnt    <= clk_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_q    <= shift_n;
            data_out   <= dout_n;
            data_valid <= valid_n;
            frame_err  <= err_n;
        end
    end

    // A held-low line after a bad stop never produces a fall pulse,
    // so IDLE naturally waits for the line to return high.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_q;
        dout_n    = data_out;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n   = START;
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_n = '0;
                    state_n   = level ? IDLE : DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n = '0;
                    // Right shift lands the first bit in the LSB.
                    shift_n   = {~level, shift_q[DATA_W-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n = '0;
                    state_n   = IDLE;
                    if (level) begin
                        dout_n  = shift_q;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tri_line_rx.sv
// Randomized bench for tri_line_rx against a frame-level model:
// each sent frame queues its expected pulse kind, word and due cycle.
module tb_tri_line_rx;
    import tri_line_pkg::*;

    localparam int DW  = DATA_W_DEF;
    localparam int CPB = CLKS_PER_BIT_DEF;
    localparam int LAT = 2 + CPB / 2 + (DW + 1) * CPB;

    typedef struct {
        logic          ok;
        logic [DW-1:0] word;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          drv_en = 1'b0;
    logic          drv_val = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;

    // Undriven line reads high through the pull-up.
    wire line = drv_en ? drv_val : 1'b1;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_valid = 0;
    int            n_ferr = 0;
    int            last_pulse = 0;
    int            prev_pulse = 0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model_dout = '0;

    tri_line_rx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .line_inN   (line),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!resetN) begin
            model_dout = '0;
            exp_q.delete();
        end else if (data_valid || frame_err) begin
            check("valid_err_excl", 32'(data_valid & frame_err), 0);
            prev_pulse = last_pulse;
            last_pulse = cyc;
            if (data_valid) n_valid++;
            if (frame_err) n_ferr++;
            if (exp_q.size() == 0) begin
                check("spurious_pulse", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", 32'(data_valid), 32'(mon_e.ok));
                check("latency", 32'(cyc), 32'(mon_e.due));
                if (mon_e.ok) model_dout = mon_e.word;
                check("data_out", 32'(data_out), 32'(model_dout));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        drv_en  = 1'b1;
        drv_val = v;
        tick(n);
    endtask

    task automatic release_line(input int n);
        drv_en = 1'b0;
        tick(n);
    endtask

    // Wire carries ~word LSB first; stop level held for 1+hold bit times.
    task automatic send(input logic [DW-1:0] w, input logic stop_ok,
                        input int hold_bits);
        exp_t          e;
        logic [DW-1:0] wb;
        int            lat_off;
        // Pulse lands within one cycle of the nominal latency.
        lat_off = 1;
        e.ok    = stop_ok;
        e.word  = w;
        e.due   = cyc + LAT + lat_off;
        exp_q.push_back(e);
        wb = ~w;
        drive(1'b0, CPB);
        for (int i = 0; i < DW; i++) drive(wb[i], CPB);
        drive(stop_ok, CPB * (1 + hold_bits));
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 400) begin
            tick(1);
            b++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    int            v0;
    int            f0;
    int            kind;
    logic [DW-1:0] w;
    logic [DW-1:0] c3_wire;

    initial begin
        resetN = 1'b0;
        drv_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_val = 1'(i);
            tick(1);
        end
        check("rst_data_out", 32'(data_out), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        drv_en = 1'b0;
        tick(2);
        resetN = 1'b1;
        tick(4);

        v0 = n_valid;
        f0 = n_ferr;
        send(8'hA5, 1'b1, 0);
        check("a5_pulses", n_valid - v0, 1);
        check("a5_ferr", n_ferr - f0, 0);
        check("a5_data", 32'(data_out), 32'h00A5);
        check("a5_busy_after", 32'(busy), 0);

        v0 = n_valid;
        f0 = n_ferr;
        drive(1'b0, 4);
        release_line(2 * CPB);
        check("glitch_busy", 32'(busy), 0);
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_data", 32'(data_out), 32'h00A5);

        v0 = n_valid;
        f0 = n_ferr;
        send(8'h3C, 1'b0, 2);
        check("ferr_pulses", n_ferr - f0, 1);
        check("ferr_valid", n_valid - v0, 0);
        check("ferr_data_kept", 32'(data_out), 32'h00A5);
        check("ferr_no_restart", 32'(busy), 0);
        release_line(4);

        v0 = n_valid;
        send(8'h01, 1'b1, 0);
        check("b2b_first", 32'(data_out), 32'h0001);
        send(8'hFE, 1'b1, 0);
        check("b2b_pulses", n_valid - v0, 2);
        check("b2b_spacing", last_pulse - prev_pulse, 10 * CPB);
        check("b2b_second", 32'(data_out), 32'h00FE);
        release_line(3);

        v0 = n_valid;
        f0 = n_ferr;
        c3_wire = ~8'hC3;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(c3_wire[i], CPB);
        drive(c3_wire[4], CPB / 2);
        resetN = 1'b0;
        drv_en = 1'b0;
        tick(3);
        resetN = 1'b1;
        tick(2 * CPB);
        check("abort_valid", n_valid - v0, 0);
        check("abort_ferr", n_ferr - f0, 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_data", 32'(data_out), 0);
        send(8'h55, 1'b1, 0);
        check("after_abort", 32'(data_out), 32'h0055);
        release_line(3);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            w    = DW'($urandom_range(0, 255));
            if (kind == 0) begin
                drive(1'b0, $urandom_range(1, 4));
                release_line(2 * CPB);
                check("rnd_glitch_idle", 32'(busy), 0);
            end else if (kind == 1) begin
                send(w, 1'b0, $urandom_range(0, 2));
                check("rnd_err_idle", 32'(busy), 0);
                release_line($urandom_range(2, 20));
            end else begin
                send(w, 1'b1, 0);
                check("rnd_word", 32'(data_out), 32'(w));
                kind = $urandom_range(0, 20);
                if (kind > 0) release_line(kind);
            end
        end

        release_line(CPB);
        wait_drain();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
